// File: rtl/led_row_serializer_if.sv
// rtl/led_row_serializer_if.sv - row-pair load handshake and serial panel signals of the LED row serializer
interface led_row_serializer_if #(
  parameter int NUM_COLS = 64
);
  logic                     enable_in;
  logic [2:0][NUM_COLS-1:0] col_top_in;
  logic [2:0][NUM_COLS-1:0] col_bot_in;
  logic                     ready_out;
  logic                     busy_out;
  logic [2:0]               rgb_top_out;
  logic [2:0]               rgb_bot_out;
  logic                     bit_clk_out;

  modport master (
    output enable_in, col_top_in, col_bot_in,
    input  ready_out, busy_out, rgb_top_out, rgb_bot_out, bit_clk_out
  );

  modport slave (
    input  enable_in, col_top_in, col_bot_in,
    output ready_out, busy_out, rgb_top_out, rgb_bot_out, bit_clk_out
  );
endinterface

// File: rtl/led_row_serializer.sv
// rtl/led_row_serializer.sv - shifts one captured row-pair into a HUB75-style panel with a generated bit clock
module led_row_serializer #(
  parameter int NUM_COLS     = 64,
  parameter int WRITE_FREQ   = 1_000_000,
  parameter int SYS_CLK_FREQ = 100_000_000
) (
  input  logic                 clk_in,
  input  logic                 n_reset_in,
  led_row_serializer_if.slave  bus
);
  localparam int HALF_PER = SYS_CLK_FREQ / (2 * WRITE_FREQ);
  localparam int CW       = $clog2(NUM_COLS);
  localparam int PW       = $clog2(HALF_PER + 1);
  localparam logic [PW-1:0] PHASE_LAST = PW'(HALF_PER - 1);
  localparam logic [CW-1:0] COL_LAST   = CW'(NUM_COLS - 1);

  if (HALF_PER < 1) begin : g_bad_half_per
    $error("led_row_serializer: SYS_CLK_FREQ must be at least 2*WRITE_FREQ");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_LO, ST_HI} state_t;

  state_t                   state, state_n;
  logic [CW-1:0]            col_idx, col_n, col_next;
  logic [PW-1:0]            phase, phase_n;
  logic [2:0][NUM_COLS-1:0] shadow_top, shadow_bot, top_n, bot_n;
  logic                     busy, busy_n;
  logic                     ready, ready_n;
  logic                     bit_clk, bit_clk_n;
  logic                     started, started_n;
  logic [2:0]               rgb_top, rgb_top_n, rgb_bot, rgb_bot_n;

  assign col_next = col_idx + CW'(1);

  always_ff @(posedge clk_in or negedge n_reset_in) begin
    if (!n_reset_in) begin
      state      <= ST_IDLE;
      col_idx    <= '0;
      phase      <= '0;
      shadow_top <= '0;
      shadow_bot <= '0;
      busy       <= 1'b0;
      ready      <= 1'b0;
      bit_clk    <= 1'b0;
      started    <= 1'b0;
      rgb_top    <= '0;
      rgb_bot    <= '0;
    end else begin
      state      <= state_n;
      col_idx    <= col_n;
      phase      <= phase_n;
      shadow_top <= top_n;
      shadow_bot <= bot_n;
      busy       <= busy_n;
      ready      <= ready_n;
      bit_clk    <= bit_clk_n;
      started    <= started_n;
      rgb_top    <= rgb_top_n;
      rgb_bot    <= rgb_bot_n;
    end
  end

  always_comb begin
    state_n   = state;
    col_n     = col_idx;
    phase_n   = phase;
    top_n     = shadow_top;
    bot_n     = shadow_bot;
    busy_n    = busy;
    ready_n   = 1'b0;
    bit_clk_n = bit_clk;
    started_n = 1'b1;
    rgb_top_n = rgb_top;
    rgb_bot_n = rgb_bot;

    // The first edge after reset release announces the idle serializer once.
    if (!started) begin
      ready_n = 1'b1;
    end

    case (state)
      ST_IDLE: begin
        if (bus.enable_in) begin
          top_n   = bus.col_top_in;
          bot_n   = bus.col_bot_in;
          col_n   = '0;
          phase_n = '0;
          state_n = ST_LO;
          busy_n  = 1'b1;
          for (int i = 0; i < 3; i++) begin
            rgb_top_n[i] = bus.col_top_in[i][0];
            rgb_bot_n[i] = bus.col_bot_in[i][0];
          end
        end
      end
      ST_LO: begin
        if (phase == PHASE_LAST) begin
          state_n   = ST_HI;
          bit_clk_n = 1'b1;
          phase_n   = '0;
        end else begin
          phase_n = phase + PW'(1);
        end
      end
      ST_HI: begin
        if (phase == PHASE_LAST) begin
          phase_n   = '0;
          bit_clk_n = 1'b0;
          if (col_idx == COL_LAST) begin
            state_n   = ST_IDLE;
            rgb_top_n = '0;
            rgb_bot_n = '0;
            busy_n    = 1'b0;
            ready_n   = 1'b1;
          end else begin
            // Data advances on the falling bit-clock edge so it is stable well before the next rise.
            col_n   = col_next;
            state_n = ST_LO;
            for (int i = 0; i < 3; i++) begin
              rgb_top_n[i] = shadow_top[i][col_next];
              rgb_bot_n[i] = shadow_bot[i][col_next];
            end
          end
        end else begin
          phase_n = phase + PW'(1);
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  assign bus.ready_out   = ready;
  assign bus.busy_out    = busy;
  assign bus.bit_clk_out = bit_clk;
  assign bus.rgb_top_out = rgb_top;
  assign bus.rgb_bot_out = rgb_bot;
endmodule

// File: tb/tb_led_row_serializer.sv
// tb/tb_led_row_serializer.sv - directed self-checking bench for led_row_serializer
module tb_led_row_serializer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b, rst_c;
  int passed = 0;
  int total  = 0;

  led_row_serializer_if #(.NUM_COLS(4))  if_a ();
  led_row_serializer_if #(.NUM_COLS(64)) if_b ();
  led_row_serializer_if #(.NUM_COLS(4))  if_c ();

  // 4 columns, half period 2
  led_row_serializer #(.NUM_COLS(4), .WRITE_FREQ(1), .SYS_CLK_FREQ(4)) dut_a (
    .clk_in(clk), .n_reset_in(rst_a), .bus(if_a.slave));
  // default parameters, half period 50
  led_row_serializer dut_b (
    .clk_in(clk), .n_reset_in(rst_b), .bus(if_b.slave));
  // 4 columns, half period 1
  led_row_serializer #(.NUM_COLS(4), .WRITE_FREQ(1), .SYS_CLK_FREQ(2)) dut_c (
    .clk_in(clk), .n_reset_in(rst_c), .bus(if_c.slave));

  int         a_rises, a_busy, a_ready_idx;
  int         a_rise_idx [4];
  logic [2:0] a_top [4];
  logic [2:0] a_bot [4];

  int   b_rises, b_bad, b_busy, b_ready_idx;
  logic b_first_busy;

  localparam logic [2:0][63:0] PA_T = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 64'hF0F0_0F0F_AAAA_5555};
  localparam logic [2:0][63:0] PA_B = {64'h8000_0000_0000_0001, 64'h0000_FFFF_0000_FFFF, 64'h1357_9BDF_2468_ACE0};
  localparam logic [2:0][63:0] PB_T = {64'hDEAD_BEEF_CAFE_F00D, 64'h0F1E_2D3C_4B5A_6978, 64'h5555_AAAA_3333_CCCC};
  localparam logic [2:0][63:0] PB_B = {64'hA5A5_5A5A_C3C3_3C3C, 64'h7FFF_FFFF_FFFF_FFFE, 64'h0000_0000_FFFF_0000};

  task automatic capture_a(input logic mid_en);
    logic prev;
    prev = 1'b0;
    a_rises = 0; a_busy = 0; a_ready_idx = -1;
    for (int k = 0; k < 4; k++) begin a_rise_idx[k] = -1; a_top[k] = 'x; a_bot[k] = 'x; end
    for (int n = 1; n <= 40 && a_ready_idx < 0; n++) begin
      @(negedge clk);
      if (if_a.busy_out) a_busy++;
      if (if_a.bit_clk_out && !prev) begin
        if (a_rises < 4) begin
          a_rise_idx[a_rises] = n; a_top[a_rises] = if_a.rgb_top_out; a_bot[a_rises] = if_a.rgb_bot_out;
        end
        a_rises++;
      end
      prev = if_a.bit_clk_out;
      if (if_a.ready_out) a_ready_idx = n;
      if (n == 1) begin if_a.col_top_in = '1; if_a.col_bot_in = '1; end
      if_a.enable_in = mid_en && (n == 6);
    end
  endtask

  task automatic capture_b(input logic [2:0][63:0] et, input logic [2:0][63:0] eb,
                           input logic [2:0][63:0] nt, input logic [2:0][63:0] nb,
                           input logic hold_en, input int stop_rises);
    logic prev;
    logic done;
    prev = 1'b0; done = 1'b0;
    b_rises = 0; b_bad = 0; b_busy = 0; b_ready_idx = -1; b_first_busy = 1'b0;
    for (int n = 1; n <= 6500 && !done; n++) begin
      @(negedge clk);
      if (n == 1) begin
        b_first_busy = if_b.busy_out;
        if_b.enable_in = hold_en; if_b.col_top_in = nt; if_b.col_bot_in = nb;
      end
      if (if_b.busy_out) b_busy++;
      if (if_b.bit_clk_out && !prev) begin
        if (b_rises < 64) begin
          if (if_b.rgb_top_out !== {et[2][b_rises], et[1][b_rises], et[0][b_rises]}) b_bad++;
          if (if_b.rgb_bot_out !== {eb[2][b_rises], eb[1][b_rises], eb[0][b_rises]}) b_bad++;
        end
        b_rises++;
        if (stop_rises > 0 && b_rises == stop_rises) done = 1'b1;
      end
      prev = if_b.bit_clk_out;
      if (if_b.ready_out) begin b_ready_idx = n; done = 1'b1; end
    end
  endtask

  task automatic test_reset();
    int ra, rb, rc;
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    if_a.enable_in = 1'b0; if_a.col_top_in = '0; if_a.col_bot_in = '0;
    if_b.enable_in = 1'b0; if_b.col_top_in = '0; if_b.col_bot_in = '0;
    if_c.enable_in = 1'b0; if_c.col_top_in = '0; if_c.col_bot_in = '0;
    repeat (3) @(negedge clk);
    total++; if ({if_a.ready_out, if_a.busy_out, if_a.bit_clk_out, if_a.rgb_top_out, if_a.rgb_bot_out} !== 9'd0)
      $display("FAIL reset_outputs_a: got %b expected 0", {if_a.ready_out, if_a.busy_out, if_a.bit_clk_out, if_a.rgb_top_out, if_a.rgb_bot_out}); else passed++;
    total++; if ({if_b.ready_out, if_b.busy_out, if_b.bit_clk_out, if_b.rgb_top_out, if_b.rgb_bot_out} !== 9'd0)
      $display("FAIL reset_outputs_b: got %b expected 0", {if_b.ready_out, if_b.busy_out, if_b.bit_clk_out, if_b.rgb_top_out, if_b.rgb_bot_out}); else passed++;
    total++; if ({if_c.ready_out, if_c.busy_out, if_c.bit_clk_out, if_c.rgb_top_out, if_c.rgb_bot_out} !== 9'd0)
      $display("FAIL reset_outputs_c: got %b expected 0", {if_c.ready_out, if_c.busy_out, if_c.bit_clk_out, if_c.rgb_top_out, if_c.rgb_bot_out}); else passed++;
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    @(negedge clk);
    total++; if (if_a.ready_out !== 1'b1) $display("FAIL reset_ready_first_edge: got %b expected 1", if_a.ready_out); else passed++;
    ra = int'(if_a.ready_out); rb = int'(if_b.ready_out); rc = int'(if_c.ready_out);
    repeat (4) begin
      @(negedge clk);
      ra += int'(if_a.ready_out); rb += int'(if_b.ready_out); rc += int'(if_c.ready_out);
    end
    total++; if (ra !== 1) $display("FAIL reset_ready_pulses_a: got %0d expected 1", ra); else passed++;
    total++; if (rb !== 1) $display("FAIL reset_ready_pulses_b: got %0d expected 1", rb); else passed++;
    total++; if (rc !== 1) $display("FAIL reset_ready_pulses_c: got %0d expected 1", rc); else passed++;
    total++; if (if_a.busy_out !== 1'b0) $display("FAIL reset_busy_after_release: got %b expected 0", if_a.busy_out); else passed++;
  endtask

  task automatic test_row_shift();
    logic [2:0] et [4] = '{3'b000, 3'b001, 3'b000, 3'b001};
    logic [2:0] eb [4] = '{3'b100, 3'b100, 3'b000, 3'b000};
    @(negedge clk);
    if_a.col_top_in = '0; if_a.col_top_in[0] = 4'b1010;
    if_a.col_bot_in = '0; if_a.col_bot_in[2] = 4'b0011;
    if_a.enable_in = 1'b1;
    capture_a(1'b0);
    total++; if (a_rises !== 4) $display("FAIL row_rise_count: got %0d expected 4", a_rises); else passed++;
    for (int k = 0; k < 4; k++) begin
      total++; if (a_rise_idx[k] !== 3 + 4 * k) $display("FAIL row_rise_time[%0d]: got %0d expected %0d", k, a_rise_idx[k], 3 + 4 * k); else passed++;
      total++; if (a_top[k] !== et[k]) $display("FAIL row_top_bits[%0d]: got %b expected %b", k, a_top[k], et[k]); else passed++;
      total++; if (a_bot[k] !== eb[k]) $display("FAIL row_bot_bits[%0d]: got %b expected %b", k, a_bot[k], eb[k]); else passed++;
    end
    total++; if (a_busy !== 16) $display("FAIL row_busy_cycles: got %0d expected 16", a_busy); else passed++;
    total++; if (a_ready_idx !== 17) $display("FAIL row_ready_latency: got %0d expected 17", a_ready_idx); else passed++;
    total++; if ({if_a.busy_out, if_a.bit_clk_out, if_a.rgb_top_out, if_a.rgb_bot_out} !== 8'd0)
      $display("FAIL row_idle_outputs: got %b expected 0", {if_a.busy_out, if_a.bit_clk_out, if_a.rgb_top_out, if_a.rgb_bot_out}); else passed++;
  endtask

  task automatic test_enable_ignored();
    logic [2:0] et [4] = '{3'b000, 3'b001, 3'b000, 3'b001};
    logic [2:0] eb [4] = '{3'b100, 3'b100, 3'b000, 3'b000};
    int extra_busy;
    @(negedge clk);
    if_a.col_top_in = '0; if_a.col_top_in[0] = 4'b1010;
    if_a.col_bot_in = '0; if_a.col_bot_in[2] = 4'b0011;
    if_a.enable_in = 1'b1;
    capture_a(1'b1);
    total++; if (a_rises !== 4) $display("FAIL ignore_rise_count: got %0d expected 4", a_rises); else passed++;
    for (int k = 0; k < 4; k++) begin
      total++; if (a_top[k] !== et[k] || a_bot[k] !== eb[k])
        $display("FAIL ignore_bits[%0d]: got %b/%b expected %b/%b", k, a_top[k], a_bot[k], et[k], eb[k]); else passed++;
    end
    total++; if (a_ready_idx !== 17) $display("FAIL ignore_ready_latency: got %0d expected 17", a_ready_idx); else passed++;
    extra_busy = 0;
    repeat (6) begin @(negedge clk); extra_busy += int'(if_a.busy_out); end
    total++; if (extra_busy !== 0) $display("FAIL ignore_no_queued_row: got %0d busy cycles expected 0", extra_busy); else passed++;
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    if_b.col_top_in = PA_T; if_b.col_bot_in = PA_B; if_b.enable_in = 1'b1;
    capture_b(PA_T, PA_B, PB_T, PB_B, 1'b1, 0);
    total++; if (b_first_busy !== 1'b1) $display("FAIL b2b_row1_start: got %b expected 1", b_first_busy); else passed++;
    total++; if (b_rises !== 64) $display("FAIL b2b_row1_rises: got %0d expected 64", b_rises); else passed++;
    total++; if (b_bad !== 0) $display("FAIL b2b_row1_bits: got %0d bad bits expected 0", b_bad); else passed++;
    total++; if (b_busy !== 6400) $display("FAIL b2b_row1_busy: got %0d expected 6400", b_busy); else passed++;
    total++; if (b_ready_idx !== 6401) $display("FAIL b2b_row1_ready: got %0d expected 6401", b_ready_idx); else passed++;
    total++; if (if_b.busy_out !== 1'b0) $display("FAIL b2b_idle_cycle: got %b expected 0", if_b.busy_out); else passed++;
    capture_b(PB_T, PB_B, PA_T, PA_B, 1'b1, 0);
    if_b.enable_in = 1'b0;
    total++; if (b_first_busy !== 1'b1) $display("FAIL b2b_row2_no_gap: got %b expected 1", b_first_busy); else passed++;
    total++; if (b_rises !== 64) $display("FAIL b2b_row2_rises: got %0d expected 64", b_rises); else passed++;
    total++; if (b_bad !== 0) $display("FAIL b2b_row2_bits: got %0d bad bits expected 0", b_bad); else passed++;
    total++; if (b_busy !== 6400) $display("FAIL b2b_row2_busy: got %0d expected 6400", b_busy); else passed++;
    total++; if (b_ready_idx !== 6401) $display("FAIL b2b_row2_ready: got %0d expected 6401", b_ready_idx); else passed++;
  endtask

  task automatic test_reset_mid_row();
    int rdy;
    @(negedge clk);
    if_b.col_top_in = PB_T; if_b.col_bot_in = PB_B; if_b.enable_in = 1'b1;
    capture_b(PB_T, PB_B, '0, '0, 1'b0, 10);
    total++; if (b_rises !== 10 || b_bad !== 0) $display("FAIL midreset_partial: got %0d rises %0d bad expected 10/0", b_rises, b_bad); else passed++;
    rst_b = 1'b0;
    @(negedge clk);
    total++; if ({if_b.ready_out, if_b.busy_out, if_b.bit_clk_out, if_b.rgb_top_out, if_b.rgb_bot_out} !== 9'd0)
      $display("FAIL midreset_outputs: got %b expected 0", {if_b.ready_out, if_b.busy_out, if_b.bit_clk_out, if_b.rgb_top_out, if_b.rgb_bot_out}); else passed++;
    rdy = 0;
    repeat (3) begin @(negedge clk); rdy += int'(if_b.ready_out); end
    total++; if (rdy !== 0) $display("FAIL midreset_no_ready: got %0d expected 0", rdy); else passed++;
    rst_b = 1'b1;
    @(negedge clk);
    total++; if (if_b.ready_out !== 1'b1) $display("FAIL midreset_release_ready: got %b expected 1", if_b.ready_out); else passed++;
    if_b.col_top_in = PA_T; if_b.col_bot_in = PB_B; if_b.enable_in = 1'b1;
    capture_b(PA_T, PB_B, '0, '0, 1'b0, 0);
    total++; if (b_rises !== 64 || b_bad !== 0) $display("FAIL midreset_new_row: got %0d rises %0d bad expected 64/0", b_rises, b_bad); else passed++;
    total++; if (b_ready_idx !== 6401) $display("FAIL midreset_new_row_ready: got %0d expected 6401", b_ready_idx); else passed++;
  endtask

  task automatic test_half_per_one();
    logic prev;
    int rises, bad, toggle_bad, busy, ready_idx, first_rise;
    prev = 1'b0; rises = 0; bad = 0; toggle_bad = 0; busy = 0; ready_idx = -1; first_rise = -1;
    @(negedge clk);
    if_c.col_top_in = '1; if_c.col_bot_in = '1; if_c.enable_in = 1'b1;
    for (int n = 1; n <= 20 && ready_idx < 0; n++) begin
      @(negedge clk);
      if (n == 1) if_c.enable_in = 1'b0;
      if (if_c.busy_out) begin
        busy++;
        if (n > 1 && if_c.bit_clk_out === prev) toggle_bad++;
      end
      if (if_c.bit_clk_out && !prev) begin
        if (first_rise < 0) first_rise = n;
        if (if_c.rgb_top_out !== 3'b111 || if_c.rgb_bot_out !== 3'b111) bad++;
        rises++;
      end
      prev = if_c.bit_clk_out;
      if (if_c.ready_out) ready_idx = n;
    end
    total++; if (rises !== 4) $display("FAIL hp1_rises: got %0d expected 4", rises); else passed++;
    total++; if (first_rise !== 2) $display("FAIL hp1_first_rise: got %0d expected 2", first_rise); else passed++;
    total++; if (toggle_bad !== 0) $display("FAIL hp1_toggle: got %0d stalls expected 0", toggle_bad); else passed++;
    total++; if (bad !== 0) $display("FAIL hp1_all_ones: got %0d bad rises expected 0", bad); else passed++;
    total++; if (busy !== 8) $display("FAIL hp1_busy: got %0d expected 8", busy); else passed++;
    total++; if (ready_idx !== 9) $display("FAIL hp1_ready: got %0d expected 9", ready_idx); else passed++;
  endtask

  initial begin
    test_reset();
    test_row_shift();
    test_enable_ignored();
    test_half_per_one();
    test_back_to_back();
    test_reset_mid_row();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit, %0d/%0d checks passed", passed, total);
    $fatal(1, "watchdog");
  end
endmodule
